// File: rtl/regbank_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// regbank_access_ctrl_if
// Bundles every bus that meets at the register-bank access controller:
// - the pipeline's write/read request port and its stall line
// - the register bank write/read port
// - the debug dump stream to the debug/UART unit
//
// Modports:
//   master : controller view. It takes pipeline requests, bank read data and
//            debug control, and drives bank accesses, the stall line and the
//            dump stream.
//   slave  : environment view. This is the pipeline, bank and debug unit
//            taken together.
// -----------------------------------------------------------------------------
interface regbank_access_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    // pipeline side
    logic              pipe_wr_en;
    logic [ADDR_W-1:0] pipe_wr_addr;
    logic [DATA_W-1:0] pipe_wr_data;
    logic              pipe_rd_en;
    logic [ADDR_W-1:0] pipe_rd_addr;
    logic              pipe_stall;
    // register bank side
    logic              rb_wr_en;
    logic [ADDR_W-1:0] rb_wr_addr;
    logic [DATA_W-1:0] rb_wr_data;
    logic              rb_rd_en;
    logic [ADDR_W-1:0] rb_rd_addr;
    logic [DATA_W-1:0] rb_rd_data;
    // debug dump side
    logic              dbg_dump_req;
    logic [DATA_W-1:0] dbg_data;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_valid;
    logic              dbg_ready;
    logic              dbg_done;

    modport master (
        input  pipe_wr_en, pipe_wr_addr, pipe_wr_data, pipe_rd_en, pipe_rd_addr,
        input  rb_rd_data, dbg_dump_req, dbg_ready,
        output pipe_stall, rb_wr_en, rb_wr_addr, rb_wr_data, rb_rd_en, rb_rd_addr,
        output dbg_data, dbg_addr, dbg_valid, dbg_done
    );

    modport slave (
        output pipe_wr_en, pipe_wr_addr, pipe_wr_data, pipe_rd_en, pipe_rd_addr,
        output rb_rd_data, dbg_dump_req, dbg_ready,
        input  pipe_stall, rb_wr_en, rb_wr_addr, rb_wr_data, rb_rd_en, rb_rd_addr,
        input  dbg_data, dbg_addr, dbg_valid, dbg_done
    );
endinterface

// File: rtl/regbank_access_ctrl.sv
// -----------------------------------------------------------------------------
// regbank_access_ctrl
// Owns the register bank ports. In RUN, pipeline accesses pass straight
// through to the bank. When a debug dump is requested, the controller does
// the following:
// - stalls the pipeline
// - keeps honouring write-back writes for DRAIN_CYCLES cycles
// - reads R0..R(NUM_REGS-1) one at a time
// - streams each word over a valid/ready handshake
// - pulses dbg_done and hands control back to the pipeline
//
// Ports:
//   clock : system clock, everything on posedge
//   reset : synchronous, active-high
//   bus   : regbank_access_ctrl_if.master. It carries the pipe_*, rb_* and
//           dbg_* signals. The rb_* outputs are combinational. pipe_stall
//           and the dbg_* outputs are registered.
//
// Configuration macro:
//   REGBANK_R0_GUARD_EN - when defined, pipeline writes to address 0 are
//                         suppressed so R0 stays constant. The dump still
//                         reads R0.
// -----------------------------------------------------------------------------
module regbank_access_ctrl #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int NUM_REGS     = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    regbank_access_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_RD,
        ST_CAP,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam int                CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic              stall_q, stall_d;
    logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
    logic [ADDR_W-1:0] dbg_addr_q, dbg_addr_d;
    logic              dbg_valid_q, dbg_valid_d;
    logic              dbg_done_q, dbg_done_d;

    // Pipeline write enable after the optional R0 guard.
    logic pipe_wr_ok;
`ifdef REGBANK_R0_GUARD_EN
    assign pipe_wr_ok = bus.pipe_wr_en && (bus.pipe_wr_addr != '0);
`else
    assign pipe_wr_ok = bus.pipe_wr_en;
`endif

    // Next-state, next-output and bank-port decode.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        idx_d        = idx_q;
        drain_cnt_d  = drain_cnt_q;
        stall_d      = stall_q;
        dbg_data_d   = dbg_data_q;
        dbg_addr_d   = dbg_addr_q;
        dbg_valid_d  = dbg_valid_q;
        dbg_done_d   = 1'b0;
        bus.rb_wr_en   = 1'b0;
        bus.rb_wr_addr = bus.pipe_wr_addr;
        bus.rb_wr_data = bus.pipe_wr_data;
        bus.rb_rd_en   = 1'b0;
        bus.rb_rd_addr = bus.pipe_rd_addr;

        unique case (state_q)
            ST_RUN: begin
                bus.rb_wr_en = pipe_wr_ok;
                bus.rb_rd_en = bus.pipe_rd_en;
                // The write issued alongside the request still goes through.
                if (bus.dbg_dump_req) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                    stall_d     = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Instructions already past the stall point still retire.
                bus.rb_wr_en = pipe_wr_ok;
                drain_cnt_d  = drain_cnt_q + 1'b1;
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d     = ST_RD;
                    idx_d       = '0;
                    drain_cnt_d = '0;
                end
            end
            ST_RD: begin
                bus.rb_rd_en   = 1'b1;
                bus.rb_rd_addr = idx_q;
                state_d        = ST_CAP;
            end
            ST_CAP: begin
                // The bank returns data one cycle after the read strobe.
                dbg_data_d  = bus.rb_rd_data;
                dbg_addr_d  = idx_q;
                dbg_valid_d = 1'b1;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (dbg_valid_q && bus.dbg_ready) begin
                    dbg_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_RD;
                    end
                end
            end
            ST_DONE: begin
                dbg_done_d = 1'b1;
                stall_d    = 1'b0;
                idx_d      = '0;
                state_d    = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the values from before this edge.
        if (reset) begin
            state_q     <= ST_RUN;
            idx_q       <= '0;
            drain_cnt_q <= '0;
            stall_q     <= 1'b0;
            dbg_data_q  <= '0;
            dbg_addr_q  <= '0;
            dbg_valid_q <= 1'b0;
            dbg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            drain_cnt_q <= drain_cnt_d;
            stall_q     <= stall_d;
            dbg_data_q  <= dbg_data_d;
            dbg_addr_q  <= dbg_addr_d;
            dbg_valid_q <= dbg_valid_d;
            dbg_done_q  <= dbg_done_d;
        end
    end

    assign bus.pipe_stall = stall_q;
    assign bus.dbg_data   = dbg_data_q;
    assign bus.dbg_addr   = dbg_addr_q;
    assign bus.dbg_valid  = dbg_valid_q;
    assign bus.dbg_done   = dbg_done_q;

endmodule

// File: tb/tb_regbank_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regbank_access_ctrl
// Self-checking bench for regbank_access_ctrl. It contains a behavioural
// register bank with a one-cycle read latency, and a shadow copy of the
// values the bank is expected to hold.
// -----------------------------------------------------------------------------
module tb_regbank_access_ctrl;

    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 5;
    localparam int NUM_REGS     = 32;
    localparam int DRAIN_CYCLES = 3;
    localparam int DUMP_CYCLES  = 1 + DRAIN_CYCLES + 3 * NUM_REGS + 1;

`ifdef REGBANK_R0_GUARD_EN
    localparam bit R0_GUARD = 1'b1;
`else
    localparam bit R0_GUARD = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    logic bank_init;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    regbank_access_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regbank_access_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [DATA_W-1:0] init_val(input int i);
        return (i == 0) ? '0 : (32'h1000_0000 | DATA_W'(i));
    endfunction

    // Behavioural bank: registered read, write on posedge.
    logic [DATA_W-1:0] bank     [NUM_REGS];
    logic [DATA_W-1:0] exp_bank [NUM_REGS];

    always @(posedge clock) begin
        if (bank_init) begin
            for (int i = 0; i < NUM_REGS; i++) bank[i] <= init_val(i);
        end else if (bus.rb_wr_en) begin
            bank[bus.rb_wr_addr] <= bus.rb_wr_data;
        end
        if (bus.rb_rd_en) bus.rb_rd_data <= bank[bus.rb_rd_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full dump.
    // - stall_word >= 0 holds dbg_ready low for stall_len extra cycles at
    //   that word.
    // - drain_wr adds a write in the 2nd DRAIN cycle and another in RD.
    task automatic run_dump(input int stall_word, input int stall_len, input bit drain_wr);
        int req_cyc;
        int n;
        logic [DATA_W-1:0] hold_data;
        logic [ADDR_W-1:0] hold_addr;

        tick();
        bus.dbg_dump_req = 1'b1;
        bus.dbg_ready    = 1'b1;
        req_cyc          = cyc;
        @(negedge clock);
        check("stall_low_in_req_cycle", 64'(bus.pipe_stall), 64'd0);
        tick();
        bus.dbg_dump_req = 1'b0;
        @(negedge clock);
        check("stall_high_in_drain", 64'(bus.pipe_stall), 64'd1);

        if (drain_wr) begin
            tick();                                   // 2nd DRAIN cycle
            bus.pipe_wr_en   = 1'b1;
            bus.pipe_wr_addr = 5'd3;
            bus.pipe_wr_data = 32'hD3A1_0003;
            @(negedge clock);
            check("drain_wr_en", 64'(bus.rb_wr_en), 64'd1);
            check("drain_wr_data", 64'(bus.rb_wr_data), 64'hD3A1_0003);
            exp_bank[3] = 32'hD3A1_0003;
            tick();                                   // 3rd DRAIN cycle
            bus.pipe_wr_en = 1'b0;
            tick();                                   // RD of word 0
            bus.pipe_wr_en   = 1'b1;
            bus.pipe_wr_data = 32'hBAD0_0003;
            @(negedge clock);
            check("rd_state_wr_blocked", 64'(bus.rb_wr_en), 64'd0);
            check("rd_state_rd_en", 64'(bus.rb_rd_en), 64'd1);
            tick();
            bus.pipe_wr_en = 1'b0;
        end

        for (int i = 0; i < NUM_REGS; i++) begin
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!bus.dbg_valid && n < 20);
            check($sformatf("word%0d_valid", i), 64'(bus.dbg_valid), 64'd1);
            check($sformatf("word%0d_addr", i), 64'(bus.dbg_addr), 64'(i));
            check($sformatf("word%0d_data", i), 64'(bus.dbg_data), 64'(exp_bank[i]));
            // A request raised mid-dump must be ignored.
            if (i == 5) bus.dbg_dump_req = 1'b1;
            if (i == 9) bus.dbg_dump_req = 1'b0;
            if (i == stall_word) begin
                bus.dbg_ready = 1'b0;
                hold_data     = bus.dbg_data;
                hold_addr     = bus.dbg_addr;
                for (int k = 0; k < stall_len; k++) begin
                    @(negedge clock);
                    check("hold_valid", 64'(bus.dbg_valid), 64'd1);
                    check("hold_addr", 64'(bus.dbg_addr), 64'(hold_addr));
                    check("hold_data", 64'(bus.dbg_data), 64'(hold_data));
                    check("hold_no_rd_en", 64'(bus.rb_rd_en), 64'd0);
                end
                bus.dbg_ready = 1'b1;
            end
        end

        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.dbg_done && n < 10);
        check("done_seen", 64'(bus.dbg_done), 64'd1);
        check("done_latency", 64'(cyc - req_cyc),
              64'(DUMP_CYCLES + ((stall_word >= 0) ? stall_len : 0)));
        check("stall_released", 64'(bus.pipe_stall), 64'd0);
        @(negedge clock);
        check("done_one_cycle", 64'(bus.dbg_done), 64'd0);
    endtask

    // RUN-mode passthrough vectors.
    typedef struct {
        logic              wr_en;
        logic [ADDR_W-1:0] wr_addr;
        logic [DATA_W-1:0] wr_data;
        logic              rd_en;
        logic [ADDR_W-1:0] rd_addr;
        logic              exp_wr_en;
        logic              exp_rd_en;
    } vec_t;

    vec_t vecs [6];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        vecs[0] = '{1'b1, 5'd5,  32'hCAFE_0005, 1'b0, 5'd0,  1'b1, 1'b0};
        vecs[1] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0,  !R0_GUARD, 1'b0};
        vecs[2] = '{1'b1, 5'd31, 32'hA5A5_A5A5, 1'b1, 5'd7,  1'b1, 1'b1};
        vecs[3] = '{1'b0, 5'd9,  32'h0000_0009, 1'b1, 5'd31, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 5'd3,  32'h3333_0003, 1'b0, 5'd0,  1'b1, 1'b0};
        vecs[5] = '{1'b0, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0,  1'b0, 1'b0};

        reset            = 1'b1;
        bank_init        = 1'b1;
        bus.pipe_wr_en   = 1'b0;
        bus.pipe_wr_addr = '0;
        bus.pipe_wr_data = '0;
        bus.pipe_rd_en   = 1'b0;
        bus.pipe_rd_addr = '0;
        bus.dbg_dump_req = 1'b0;
        bus.dbg_ready    = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) exp_bank[i] = init_val(i);
        repeat (2) @(posedge clock);
        #1;
        bank_init = 1'b0;
        @(negedge clock);
        check("rst_stall", 64'(bus.pipe_stall), 64'd0);
        check("rst_valid", 64'(bus.dbg_valid), 64'd0);
        check("rst_done", 64'(bus.dbg_done), 64'd0);
        check("rst_data", 64'(bus.dbg_data), 64'd0);
        check("rst_addr", 64'(bus.dbg_addr), 64'd0);
        reset = 1'b0;

        // RUN passthrough table
        for (int v = 0; v < 6; v++) begin
            tick();
            bus.pipe_wr_en   = vecs[v].wr_en;
            bus.pipe_wr_addr = vecs[v].wr_addr;
            bus.pipe_wr_data = vecs[v].wr_data;
            bus.pipe_rd_en   = vecs[v].rd_en;
            bus.pipe_rd_addr = vecs[v].rd_addr;
            @(negedge clock);
            check($sformatf("vec%0d_wr_en", v), 64'(bus.rb_wr_en), 64'(vecs[v].exp_wr_en));
            check($sformatf("vec%0d_rd_en", v), 64'(bus.rb_rd_en), 64'(vecs[v].exp_rd_en));
            check($sformatf("vec%0d_stall", v), 64'(bus.pipe_stall), 64'd0);
            if (vecs[v].exp_wr_en) begin
                check($sformatf("vec%0d_wr_addr", v), 64'(bus.rb_wr_addr), 64'(vecs[v].wr_addr));
                check($sformatf("vec%0d_wr_data", v), 64'(bus.rb_wr_data), 64'(vecs[v].wr_data));
                exp_bank[vecs[v].wr_addr] = vecs[v].wr_data;
            end
            if (vecs[v].exp_rd_en)
                check($sformatf("vec%0d_rd_addr", v), 64'(bus.rb_rd_addr), 64'(vecs[v].rd_addr));
        end
        tick();
        bus.pipe_wr_en = 1'b0;
        bus.pipe_rd_en = 1'b0;

        // Plain dump with dbg_ready held high
        run_dump(-1, 0, 1'b0);

        // Backpressure at word 7 plus DRAIN/RD write checks
        run_dump(7, 10, 1'b1);

        // Reset in the middle of SEND for word 2
        tick();
        bus.dbg_dump_req = 1'b1;
        bus.dbg_ready    = 1'b1;
        tick();
        bus.dbg_dump_req = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(bus.dbg_valid && bus.dbg_addr == 5'd2) && n < 40);
        bus.dbg_ready = 1'b0;
        check("pre_reset_word2", 64'(bus.dbg_addr), 64'd2);
        tick();
        reset = 1'b1;
        tick();
        reset            = 1'b0;
        bus.pipe_rd_en   = 1'b1;
        bus.pipe_rd_addr = 5'd9;
        @(negedge clock);
        check("midrst_stall", 64'(bus.pipe_stall), 64'd0);
        check("midrst_valid", 64'(bus.dbg_valid), 64'd0);
        check("midrst_addr", 64'(bus.dbg_addr), 64'd0);
        check("midrst_data", 64'(bus.dbg_data), 64'd0);
        check("midrst_run_rd_en", 64'(bus.rb_rd_en), 64'd1);
        bus.dbg_ready  = 1'b1;
        bus.pipe_rd_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("midrst_no_done", 64'(bus.dbg_done), 64'd0);
        end

        // A fresh request starts again from R0
        run_dump(-1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
